// File: rtl/seg_scan_pkg.sv
// ---------------------------------------------------------------------------
// seg_scan_pkg
//   Shared definitions for the 4-digit 7-segment scan controller:
//   FSM state encoding, pin idle levels and the hex -> segment lookup table.
//   Segment vectors are {g,f,e,d,c,b,a}, active-low.
// ---------------------------------------------------------------------------
package seg_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_e;

    localparam logic [3:0] AN_OFF  = 4'hF;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Entry [n] is the active-low pattern for hex digit n (index 15 listed first).
    localparam logic [15:0][6:0] HEX7_TABLE = {
        7'h0E,  // F
        7'h06,  // E
        7'h21,  // d
        7'h46,  // C
        7'h03,  // b
        7'h08,  // A
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

endpackage

// File: rtl/hex7seg.sv
// ---------------------------------------------------------------------------
// hex7seg
//   Combinational 4-bit hex to 7-segment decoder, active-low outputs.
// Ports:
//   hex_i  in  4  hex value
//   seg_o  out 7  cathode pattern {g,f,e,d,c,b,a}, active-low
// ---------------------------------------------------------------------------
module hex7seg
    import seg_scan_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX7_TABLE[hex_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
//   Time-multiplexing scan scheduler for a shared 4-digit 7-segment display.
//   Each digit owns the cathode bus for PRESCALE cycles: BLANK_CYC cycles with
//   anodes off (anti-ghosting guard) followed by the lit portion. The digit
//   value is sampled once at the start of its slot.
//
// Ports:
//   clk         in   1  system clock, rising edge
//   rst         in   1  asynchronous active-low reset
//   en          in   1  scan enable; 0 forces the display dark
//   seg0wr..3wr in   5  digit registers: [3:0] hex value, [4] blank
//   blink_mask  in   4  per-digit blink select (only with SCAN_BLINK_EN)
//   an          out  4  anode enables, active-low
//   seg         out  7  cathodes {g,f,e,d,c,b,a}, active-low
//   sel         out  2  digit currently owning the bus
//
// Configuration macro:
//   SCAN_BLINK_EN  adds blink_mask and a blink phase that toggles every
//                  BLINK_DIV full rotations; masked digits go dark while the
//                  phase is 1.
// ---------------------------------------------------------------------------
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int PRESCALE  = 50000,
    parameter int BLANK_CYC = 16,
    parameter int BLINK_DIV = 125
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [4:0] seg0wr,
    input  logic [4:0] seg1wr,
    input  logic [4:0] seg2wr,
    input  logic [4:0] seg3wr,
`ifdef SCAN_BLINK_EN
    input  logic [3:0] blink_mask,
`endif
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic [1:0] sel
);

    localparam int CNT_W = $clog2(PRESCALE);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [4:0]       cur_q, cur_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             wrap;        // slot 3 -> slot 0 transition this cycle
    logic             blink_dark;  // blink forces the next-state digit dark
    logic [6:0]       dec_seg;
    logic [4:0]       digit_w [4];

    assign digit_w[0] = seg0wr;
    assign digit_w[1] = seg1wr;
    assign digit_w[2] = seg2wr;
    assign digit_w[3] = seg3wr;

    // Slot sequencing. cnt runs across the whole slot: BLANK covers
    // 0..BLANK_CYC-1, SHOW covers BLANK_CYC..PRESCALE-1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        cur_d   = cur_q;
        wrap    = 1'b0;
        if (!en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            sel_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    sel_d   = '0;
                    cur_d   = digit_w[0];
                end
                ST_BLANK: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == SLOT_LAST) begin
                        state_d = ST_BLANK;
                        cnt_d   = '0;
                        sel_d   = sel_q + 2'd1;
                        cur_d   = digit_w[sel_q + 2'd1];
                        wrap    = (sel_q == 2'd3);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    sel_d   = '0;
                end
            endcase
        end
    end

`ifdef SCAN_BLINK_EN
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

    logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_ph_q, blink_ph_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        if (state_d == ST_IDLE) begin
            blink_cnt_d = '0;
            blink_ph_d  = 1'b0;
        end else if (wrap) begin
            if (blink_cnt_q == BLK_LAST) begin
                blink_cnt_d = '0;
                blink_ph_d  = ~blink_ph_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
        end
    end

    assign blink_dark = blink_ph_d & blink_mask[sel_d];
`else
    assign blink_dark = 1'b0;
`endif

    // Decode the value that will own the bus after this edge so the pins
    // are driven straight from flops.
    hex7seg u_dec (
        .hex_i (cur_d[3:0]),
        .seg_o (dec_seg)
    );

    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        if (state_d == ST_SHOW && !cur_d[4] && !blink_dark) begin
            an_d[sel_d] = 1'b0;
            seg_d       = dec_seg;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            cur_q   <= '0;
            an_q    <= AN_OFF;
            seg_q   <= SEG_OFF;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            cur_q   <= cur_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign sel = sel_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_ctrl
//   Directed bench for seg_scan_ctrl with PRESCALE=8, BLANK_CYC=2,
//   BLINK_DIV=2. One slot is 8 cycles (2 dark + 6 lit), a rotation is 32.
// ---------------------------------------------------------------------------
module tb_seg_scan_ctrl;

    logic       clk;
    logic       rst;
    logic       en;
    logic [4:0] seg0wr, seg1wr, seg2wr, seg3wr;
    logic [3:0] blink_mask;
    logic [3:0] an;
    logic [6:0] seg;
    logic [1:0] sel;

    int n_checks = 0;
    int n_fail   = 0;

    seg_scan_ctrl #(
        .PRESCALE  (8),
        .BLANK_CYC (2),
        .BLINK_DIV (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .seg0wr     (seg0wr),
        .seg1wr     (seg1wr),
        .seg2wr     (seg2wr),
        .seg3wr     (seg3wr),
`ifdef SCAN_BLINK_EN
        .blink_mask (blink_mask),
`endif
        .an         (an),
        .seg        (seg),
        .sel        (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       en;
        logic [3:0] an;
        logic [6:0] seg;
        logic [1:0] sel;
    } vec_t;

    vec_t vecs [40];

    // Lit patterns for digits 01,08,00,0F in slots 0..3.
    logic [3:0] an_lit  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0] seg_lit [4] = '{7'h79, 7'h00, 7'h40, 7'h0E};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] ea,
                         input logic [6:0] es, input logic [1:0] esel);
        n_checks++;
        if (an !== ea || seg !== es || sel !== esel) begin
            n_fail++;
            $display("FAIL %s: got an=%h seg=%h sel=%0d, expected an=%h seg=%h sel=%0d",
                     name, an, seg, sel, ea, es, esel);
        end else begin
            $display("ok   %s: an=%h seg=%h sel=%0d", name, an, seg, sel);
        end
    endtask

    // Expected trace of 40 cycles from enable; dark_slot (0..3) marks a
    // digit with its blank bit set, -1 for none.
    task automatic fill_table(input int dark_slot);
        for (int k = 0; k < 40; k++) begin
            int s;
            int c;
            s = (k / 8) % 4;
            c = k % 8;
            vecs[k].en  = 1'b1;
            vecs[k].sel = 2'(s);
            if (c < 2 || s == dark_slot) begin
                vecs[k].an  = 4'hF;
                vecs[k].seg = 7'h7F;
            end else begin
                vecs[k].an  = an_lit[s];
                vecs[k].seg = seg_lit[s];
            end
        end
    endtask

    task automatic run_table(input string name);
        for (int k = 0; k < 40; k++) begin
            en = vecs[k].en;
            tick();
            check($sformatf("%s[%0d]", name, k), vecs[k].an, vecs[k].seg, vecs[k].sel);
        end
    endtask

    task automatic go_idle();
        en = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        rst        = 1'b0;
        en         = 1'b1;
        blink_mask = 4'b0000;
        seg0wr     = 5'h01;
        seg1wr     = 5'h08;
        seg2wr     = 5'h00;
        seg3wr     = 5'h0F;

        // Reset held with en=1: dark and digit 0.
        tick();
        tick();
        check("reset_hold", 4'hF, 7'h7F, 2'd0);
        en = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        tick();
        tick();
        check("idle_after_release", 4'hF, 7'h7F, 2'd0);

        // Normal scan order over a full rotation plus wrap.
        fill_table(-1);
        run_table("scan");

        // Digit 2 blanked.
        go_idle();
        seg2wr = 5'h10;
        fill_table(2);
        run_table("blank2");
        seg2wr = 5'h00;

        // Mid-slot write to digit 1 is deferred to its next slot.
        go_idle();
        seg1wr = 5'h01;
        en = 1'b1;
        for (int k = 0; k < 48; k++) begin
            tick();
            if (k >= 10 && k <= 15)
                check($sformatf("midwr_old[%0d]", k), 4'hD, 7'h79, 2'd1);
            if (k == 11)
                seg1wr = 5'h05;
            if (k >= 42)
                check($sformatf("midwr_new[%0d]", k), 4'hD, 7'h12, 2'd1);
        end
        seg1wr = 5'h08;

        // en drop mid-SHOW of slot 2, then restart at digit 0.
        go_idle();
        en = 1'b1;
        for (int k = 0; k <= 20; k++) tick();
        check("abort_pre", 4'hB, 7'h40, 2'd2);
        en = 1'b0;
        tick();
        check("abort_dark", 4'hF, 7'h7F, 2'd0);
        en = 1'b1;
        tick();
        check("restart_blank0", 4'hF, 7'h7F, 2'd0);
        tick();
        check("restart_blank1", 4'hF, 7'h7F, 2'd0);
        tick();
        check("restart_show", 4'hE, 7'h79, 2'd0);

        // Asynchronous reset pulse mid-SHOW.
        tick();
        tick();
        check("rst_pre", 4'hE, 7'h79, 2'd0);
        #2;
        rst = 1'b0;
        #1;
        check("rst_async", 4'hF, 7'h7F, 2'd0);
        tick();
        check("rst_held", 4'hF, 7'h7F, 2'd0);
        rst = 1'b1;
        tick();
        check("rst_rel_blank", 4'hF, 7'h7F, 2'd0);
        tick();
        tick();
        check("rst_rel_show", 4'hE, 7'h79, 2'd0);

`ifdef SCAN_BLINK_EN
        // Digit 0 blinks: lit 2 rotations, dark 2, lit again.
        go_idle();
        blink_mask = 4'b0001;
        en = 1'b1;
        for (int k = 0; k < 192; k++) begin
            int r;
            tick();
            r = k / 32;
            if (k % 32 == 2) begin
                if (r == 2 || r == 3)
                    check($sformatf("blink_d0_rot%0d", r), 4'hF, 7'h7F, 2'd0);
                else
                    check($sformatf("blink_d0_rot%0d", r), 4'hE, 7'h79, 2'd0);
            end
            if (k % 32 == 10)
                check($sformatf("blink_d1_rot%0d", r), 4'hD, 7'h00, 2'd1);
        end
        blink_mask = 4'b0000;
`endif

        en = 1'b0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
